gpu_cmd_tx: RTL and testbench

//  CPU-side transmitter for the GPU 16-bit cpuline command protocol. Accepts (cmd, param)

---
 rtl/gpu_defs.sv | 28 ++
 rtl/gpu_cmd_tx_if.sv | 27 ++
 rtl/gpu_cmd_fifo.sv | 60 ++++++
 rtl/gpu_cmd_tx.sv | 108 ++++++++++
 tb/tb_gpu_cmd_tx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_defs.sv
// Shared GPU command-protocol definitions: opcodes, slot roles and text-screen geometry.
package gpu_defs;

  localparam logic [15:0] GPU_NOP  = 16'h0000;
  localparam logic [15:0] GPU_MODE = 16'h00C0;
  localparam logic [15:0] GPU_PUTC = 16'h00C1;
  localparam logic [15:0] GPU_BKSP = 16'h00C2;
  localparam logic [15:0] GPU_SETY = 16'h00C3;
  localparam logic [15:0] GPU_SETX = 16'h00C4;
  localparam logic [15:0] GPU_CLS  = 16'h00C5;
  localparam logic [15:0] GPU_NL   = 16'h00C6;

  localparam int GPU_TXT_COLS = 40;
  localparam int GPU_TXT_ROWS = 25;

  // Role of the GPU's next sampling edge on cpuline.
  typedef enum logic [1:0] {
    ROLE_CMD   = 2'd0,
    ROLE_PARAM = 2'd1,
    ROLE_EXEC  = 2'd2
  } role_e;

  // The GPU wedges on anything outside the contiguous C0..C6 opcode range.
  function automatic logic isLegalOp(input logic [15:0] op);
    return (op >= GPU_MODE) && (op <= GPU_NL);
  endfunction

endpackage

// File: rtl/gpu_cmd_tx_if.sv
// CPU-side request handshake plus the GPU-facing outputs of the command transmitter.
interface gpu_cmd_tx_if #(
  parameter int AW = 3
);

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_cmd;
  logic [15:0] in_param;
  logic [15:0] cpuline;
  logic        busy;
  logic        err;
  logic [AW:0] level;

  // The CPU bus decode drives requests and observes status.
  modport master (
    output in_valid, in_cmd, in_param,
    input  in_ready, cpuline, busy, err, level
  );

  // The transmitter consumes requests and drives cpuline and status.
  modport slave (
    input  in_valid, in_cmd, in_param,
    output in_ready, cpuline, busy, err, level
  );

endinterface

// File: rtl/gpu_cmd_fifo.sv
// Synchronous FIFO holding {cmd, param} entries waiting for a CMD slot.
module gpu_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   level_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  // Storage needs no reset; a flush is just a pointer/level reset.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; level tracks push/pop balance.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/gpu_cmd_tx.sv
// CPU-to-GPU command transmitter: validates and queues requests, then serialises each one
// as CMD, PARAM, EXEC words in step with the GPU's slot sequencer; idles with NOP pairs.
module gpu_cmd_tx
  import gpu_defs::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         clr,
  gpu_cmd_tx_if.slave  bus
);

  role_e       role_q;
  role_e       role_d;
  logic [15:0] cpuline_q;
  logic [15:0] cpuline_d;
  logic [15:0] lastCmd_q;
  logic [15:0] lastCmd_d;
  logic [15:0] paramHold_q;
  logic [15:0] paramHold_d;
  logic        err_q;
  logic        err_d;

  logic        accept;
  logic        legal;
  logic        fifoPush;
  logic        fifoPop;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [31:0] fifoHead;
  logic [AW:0] fifoLevel;

  // Illegal opcodes still complete the handshake; they are just never queued.
  assign accept   = bus.in_valid && !fifoFull;
  assign legal    = isLegalOp(bus.in_cmd);
  assign fifoPush = accept && legal;
  assign err_d    = accept && !legal;

  gpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .push_i  (fifoPush),
    .pop_i   (fifoPop),
    .wdata_i ({bus.in_cmd, bus.in_param}),
    .rdata_o (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (fifoLevel)
  );

  // Advance the slot role and choose the word the GPU will sample at the next edge.
  always_comb begin
    role_d      = role_q;
    cpuline_d   = GPU_NOP;
    lastCmd_d   = lastCmd_q;
    paramHold_d = paramHold_q;
    fifoPop     = 1'b0;

    case (role_q)
      ROLE_CMD:   role_d = ROLE_PARAM;
      ROLE_PARAM: role_d = (lastCmd_q != GPU_NOP) ? ROLE_EXEC : ROLE_CMD;
      default:    role_d = ROLE_CMD;
    endcase

    case (role_d)
      ROLE_CMD: begin
        if (!fifoEmpty) begin
          fifoPop     = 1'b1;
          cpuline_d   = fifoHead[31:16];
          paramHold_d = fifoHead[15:0];
        end
        lastCmd_d = cpuline_d;
      end
      ROLE_PARAM: cpuline_d = (lastCmd_q != GPU_NOP) ? paramHold_q : GPU_NOP;
      default:    cpuline_d = GPU_NOP;
    endcase
  end

  // Role, output word and per-command bookkeeping registers; clr abandons any command in flight.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      role_q      <= ROLE_CMD;
      cpuline_q   <= GPU_NOP;
      lastCmd_q   <= GPU_NOP;
      paramHold_q <= '0;
      err_q       <= 1'b0;
    end else begin
      role_q      <= role_d;
      cpuline_q   <= cpuline_d;
      lastCmd_q   <= lastCmd_d;
      paramHold_q <= paramHold_d;
      err_q       <= err_d;
    end
  end

  // Busy while anything is queued or a real command still owns its PARAM/EXEC slots.
  assign bus.busy     = (fifoLevel != '0) || ((role_q != ROLE_CMD) && (lastCmd_q != GPU_NOP));
  assign bus.in_ready = !fifoFull;
  assign bus.cpuline  = cpuline_q;
  assign bus.err      = err_q;
  assign bus.level    = fifoLevel;

endmodule

// File: tb/tb_gpu_cmd_tx.sv
// Self-checking bench for gpu_cmd_tx: a word-stream reference model (commands expand to
// cmd/param/0 groups, idle time to 0/0 groups) compared every cycle, plus literal checkpoints.
module tb_gpu_cmd_tx;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;

  gpu_cmd_tx_if #(.AW(AW)) bus ();

  gpu_cmd_tx #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: queued requests, words still to emit for the current group,
  // the word currently on cpuline and its position inside its group.
  logic [31:0] modelQ[$];
  logic [15:0] modelPend[$];
  logic [15:0] expWord = 16'h0;
  int          groupPos = 0;
  bit          groupReal = 1'b0;
  bit          expErr = 1'b0;
  bit          mAccepted;
  bit          mLegal;
  logic [31:0] mHead;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] c, input logic [15:0] p);
    bus.in_valid = v;
    bus.in_cmd   = c;
    bus.in_param = p;
  endtask

  // Model: on each edge emit the next word of the current group, starting a new group
  // (queued command or NOP pair) when the previous one is exhausted; then take the request.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      modelQ.delete();
      modelPend.delete();
      modelPend.push_back(16'h0);
      expWord   = 16'h0;
      groupPos  = 0;
      groupReal = 1'b0;
      expErr    = 1'b0;
    end else begin
      mAccepted = bus.in_valid && (modelQ.size() < DEPTH);
      mLegal    = (bus.in_cmd >= 16'h00C0) && (bus.in_cmd <= 16'h00C6);
      if (modelPend.size() == 0) begin
        if (modelQ.size() != 0) begin
          mHead = modelQ.pop_front();
          modelPend.push_back(mHead[31:16]);
          modelPend.push_back(mHead[15:0]);
          modelPend.push_back(16'h0);
          groupReal = 1'b1;
        end else begin
          modelPend.push_back(16'h0);
          modelPend.push_back(16'h0);
          groupReal = 1'b0;
        end
        groupPos = -1;
      end
      expWord = modelPend.pop_front();
      groupPos++;
      expErr = mAccepted && !mLegal;
      if (mAccepted && mLegal) begin
        modelQ.push_back({bus.in_cmd, bus.in_param});
      end
    end
  end

  // Every cycle, away from the active edge, hold the DUT outputs against the model.
  always @(negedge clk) begin
    checkOutput("cpuline", 32'(bus.cpuline), 32'(expWord));
    checkOutput("in_ready", 32'(bus.in_ready), 32'(modelQ.size() < DEPTH));
    checkOutput("level", 32'(bus.level), 32'(modelQ.size()));
    checkOutput("busy", 32'(bus.busy), 32'((modelQ.size() != 0) || (groupReal && groupPos != 0)));
    checkOutput("err", 32'(bus.err), 32'(expErr));
  end

  // Release clr and send one PUTC 'A', checking the fixed word timing edge by edge.
  task automatic runPutc(input string tag);
    @(negedge clk);
    clr = 1'b0;
    applyStimulus(1'b1, 16'h00C1, 16'h0041);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput({tag, "_e1_cpuline"}, 32'(bus.cpuline), 32'h0);
    checkOutput({tag, "_e1_level"}, 32'(bus.level), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_e2_cmd"}, 32'(bus.cpuline), 32'h00C1);
    checkOutput({tag, "_e2_level"}, 32'(bus.level), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_e3_param"}, 32'(bus.cpuline), 32'h0041);
    checkOutput({tag, "_e3_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_e4_exec"}, 32'(bus.cpuline), 32'h0);
    checkOutput({tag, "_e4_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_e5_nop"}, 32'(bus.cpuline), 32'h0);
    checkOutput({tag, "_e5_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic waitDrained(input string name);
    int cycles = 0;
    while ((bus.level != '0 || bus.busy) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 200) reportTimeout(name);
  endtask

  function automatic logic [31:0] burstItem(input int idx);
    if (idx == 0) return {16'h00C4, 16'h0005};
    if (idx == 1) return {16'h00C3, 16'h0002};
    return {16'h00C1, 16'(16'h0041 + idx)};
  endfunction

  initial begin
    int          idx;
    int          cycles;
    bit          wasReady;
    logic [31:0] item;
    logic [15:0] rc;

    applyStimulus(1'b0, 16'h0, 16'h0);
    #1 clr = 1'b1;

    // Reset values.
    @(negedge clk);
    checkOutput("rst_cpuline", 32'(bus.cpuline), 32'h0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_level", 32'(bus.level), 32'd0);

    // Single PUTC.
    runPutc("s1");

    // Illegal opcodes: C7 then 0.
    @(negedge clk);
    applyStimulus(1'b1, 16'h00C7, 16'h1234);
    @(negedge clk);
    checkOutput("s3_err_c7", 32'(bus.err), 32'd1);
    checkOutput("s3_level_c7", 32'(bus.level), 32'd0);
    applyStimulus(1'b1, 16'h0000, 16'h0000);
    @(negedge clk);
    checkOutput("s3_err_zero", 32'(bus.err), 32'd1);
    checkOutput("s3_level_zero", 32'(bus.level), 32'd0);
    applyStimulus(1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checkOutput("s3_err_clear", 32'(bus.err), 32'd0);

    // Burst with in_valid held until the FIFO is full.
    idx = 0;
    item = burstItem(idx);
    applyStimulus(1'b1, item[31:16], item[15:0]);
    cycles = 0;
    while (bus.level != 4'(DEPTH) && cycles < 200) begin
      wasReady = bus.in_ready;
      @(negedge clk);
      cycles++;
      if (wasReady) begin
        idx++;
        item = burstItem(idx);
        applyStimulus(1'b1, item[31:16], item[15:0]);
      end
    end
    if (cycles >= 200) reportTimeout("s2_fill");
    checkOutput("s2_level_full", 32'(bus.level), 32'd8);
    checkOutput("s2_not_ready", 32'(bus.in_ready), 32'd0);

    // Full plus pop: no accept on the pop edge, accept on the next.
    cycles = 0;
    while (bus.level == 4'(DEPTH) && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 20) reportTimeout("s4_pop");
    checkOutput("s4_pop_no_accept", 32'(bus.level), 32'd7);
    checkOutput("s4_ready_after_pop", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    checkOutput("s4_refill", 32'(bus.level), 32'd8);
    applyStimulus(1'b0, 16'h0, 16'h0);
    waitDrained("s2_drain");

    // Reset while the PARAM word of a real command is on cpuline.
    @(negedge clk);
    applyStimulus(1'b1, 16'h00C3, 16'h0007);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 16'h0);
    cycles = 0;
    while (!(groupReal && groupPos == 1 && expWord == 16'h0007) && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 20) reportTimeout("s5_find_param");
    #2 clr = 1'b1;
    #1;
    checkOutput("s5_rst_cpuline", 32'(bus.cpuline), 32'h0);
    checkOutput("s5_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("s5_rst_level", 32'(bus.level), 32'd0);
    checkOutput("s5_rst_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("s5_rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    runPutc("s5");

    // Idle, then push on the edge that loads a NOP PARAM word.
    repeat (10) @(negedge clk);
    cycles = 0;
    while (!(groupPos == 0 && !groupReal) && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 10) reportTimeout("s6_align");
    applyStimulus(1'b1, 16'h00C5, 16'h0000);
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 16'h0);
    checkOutput("s6_param_slot_nop", 32'(bus.cpuline), 32'h0);
    checkOutput("s6_queued", 32'(bus.level), 32'd1);
    @(negedge clk);
    checkOutput("s6_cmd_slot", 32'(bus.cpuline), 32'h00C5);
    waitDrained("s6_drain");

    // Randomised traffic with occasional illegal opcodes and rare resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        #2 clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
      if ($urandom_range(0, 99) < 10) rc = 16'($urandom);
      else rc = 16'(16'h00C0 + $urandom_range(0, 6));
      applyStimulus(($urandom_range(0, 99) < 55), rc, 16'($urandom));
    end
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 16'h0);
    waitDrained("rand_drain");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
